fifo_demux4: RTL and testbench
==============================

Name: fifo_demux4

Overview:
- 1-to-4 distributor: the write-side counterpart of the 4-input FIFO-to-mux path.
- Accepts a single byte stream with a per-word 2-bit channel select.
- Buffers each word in one of four independent channel FIFOs, A..D.
- Each channel is drained by its own consumer through a read/empty handshake.
- Sits between a single producer (e.g. the mux output FIFO) and four downstream consumers.

Parameters:
WIDTH, 8, data word width
DEPTH, 8, entries per channel FIFO; must be a power of 2, >= 2
ADDR_W, 3, log2(DEPTH)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
DATA_IN  in  WIDTH  write data
write  in  1  write strobe, one word per cycle while high
select  in  2  destination channel for DATA_IN (0=A, 1=B, 2=C, 3=D), sampled with write
full  out  1  channel addressed by the current select is full (combinational from select and state)
full_ch  out  4  per-channel full flags, bit0=A .. bit3=D
read  in  4  per-channel read strobes, bit0=A .. bit3=D
empty  out  4  per-channel empty flags
DATA_OUT_A  out  WIDTH  channel A read data
DATA_OUT_B  out  WIDTH  channel B read data
DATA_OUT_C  out  WIDTH  channel C read data
DATA_OUT_D  out  WIDTH  channel D read data
drop_count  out  8  saturating count of writes rejected because the target channel was full

Behaviour:
- Reset (reset=0, async): all pointers = 0; empty = 4'b1111; full_ch = 0; DATA_OUT_A..D = 0; drop_count = 0.
  - Outputs hold these values while reset is low.
  - Release is sampled on the next rising clock edge.
- Write, rising edge with write=1:
  - Word goes to channel ch = select if full_ch[ch] is 0 before the edge.
  - Otherwise the word is dropped, drop_count increments, and it saturates at 255.
  - No other channel is affected.
- Read, rising edge with read[i]=1 and empty[i]=0:
  - DATA_OUT_x is loaded with the head entry; one-cycle latency, registered output.
  - The read pointer advances.
  - read[i] while empty[i]=1 is ignored; DATA_OUT_x holds its value.
- DATA_OUT_x holds the last popped word until the next successful read on that channel.
- Flags derive from the pre-edge state and are registered/pointer-derived:
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ, lower ADDR_W bits equal.
  - Pointers are ADDR_W+1 bits and wrap modulo 2*DEPTH; storage index is the low ADDR_W bits.
- Simultaneous read and write on the same channel:
  - Not full and not empty: both occur; occupancy unchanged.
  - Empty: write accepted, read ignored; empty deasserts after the edge.
  - Full: write dropped (full evaluated pre-edge) even though the read frees an entry; read succeeds.
- Writes to one channel and reads on other channels in the same cycle are fully independent.
- Reset asserted mid-operation: all buffered words are discarded immediately and all outputs return to reset values.
- No X propagation: an unwritten location is never presented, because reads are blocked when empty.

Decomposition:
- Shared package fifo_pkg:
  - WIDTH/DEPTH defaults.
  - Channel index constants CH_A=0, CH_B=1, CH_C=2, CH_D=3.
- One natural sub-module, demux_chan_fifo: a single-channel sync FIFO with a registered read, instanced four times.
- The top level contains only select decode, write gating, drop counter and output wiring.

Test Plan:
1. Reset: hold reset=0 for 2 cycles, then release -> empty=4'b1111, full_ch=0, all DATA_OUT=0, drop_count=0.
2. Routing: write 8'h05/sel0, 8'h08/sel1, 8'h0A/sel2, 8'h2D/sel3, then pulse read=4'b1111 -> next cycle A=05, B=08, C=0A, D=2D, empty=4'b1111.
3. Fill/overflow: write 9 words 1..9 to channel C -> full_ch[2]=1 after the 8th word, 9th word dropped, drop_count=1; drain 8 reads -> 1..8 in order, empty[2]=1.
4. Wrap-around: on channel B, write 6, read 6, write 6 (values 10..15) -> reads return 10..15 in order across the pointer wrap.
5. Simultaneous: with channel A full, assert write(sel0, 8'hFF) and read[0] together -> pop returns the oldest word, 8'hFF dropped, drop_count increments; with A empty, same stimulus -> write accepted, DATA_OUT_A unchanged.
6. Async reset mid-stream: with 3 words in D, drop reset between clock edges -> empty[3]=1 and DATA_OUT_D=0 immediately, before the next edge; drop_count saturation is checked separately with 300 dropped writes -> 255.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and channel indices for the 1-to-4 FIFO distributor
package fifo_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;
  localparam int CH_A = 0;
  localparam int CH_B = 1;
  localparam int CH_C = 2;
  localparam int CH_D = 3;
endpackage

// File: rtl/demux_chan_fifo.sv
// demux_chan_fifo: single-channel sync FIFO with registered read data; ports: clock, reset (async low), wr_i/din_i push, rd_i pop, dout_o last popped word, empty_o/full_o pointer-derived flags
module demux_chan_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam logic [ADDR_W:0] ONE = 1;
  logic [ADDR_W:0]  wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push, pop;
  // Pointers carry one extra wrap bit so full and empty are distinguishable
  always_comb begin
    empty_o = wr_q == rd_q;
    full_o  = (wr_q[ADDR_W] != rd_q[ADDR_W]) && (wr_q[ADDR_W-1:0] == rd_q[ADDR_W-1:0]);
    push    = wr_i && !full_o;
    pop     = rd_i && !empty_o;
    wr_d    = push ? wr_q + ONE : wr_q;
    rd_d    = pop ? rd_q + ONE : rd_q;
    dout_d  = pop ? mem_q[rd_q[ADDR_W-1:0]] : dout_q;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      dout_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      dout_q <= dout_d;
    end
  end
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q[ADDR_W-1:0]] <= din_i;
  end
  assign dout_o = dout_q;
endmodule

// File: rtl/fifo_demux4.sv
// fifo_demux4: routes a byte stream into four channel FIFOs by select; ports: clock, reset (async low), DATA_IN/write/select producer side, full/full_ch flags, read/empty/DATA_OUT_A..D consumer side, drop_count saturating rejects
import fifo_pkg::*;
module fifo_demux4 #(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             write,
  input  logic [1:0]       select,
  output logic             full,
  output logic [3:0]       full_ch,
  input  logic [3:0]       read,
  output logic [3:0]       empty,
  output logic [WIDTH-1:0] DATA_OUT_A,
  output logic [WIDTH-1:0] DATA_OUT_B,
  output logic [WIDTH-1:0] DATA_OUT_C,
  output logic [WIDTH-1:0] DATA_OUT_D,
  output logic [7:0]       drop_count
);
  logic [3:0]       wr_en;
  logic [7:0]       drop_q, drop_d;
  logic [WIDTH-1:0] dout [4];
  // Fullness is judged before the edge, so a same-cycle read never rescues a write
  always_comb begin
    full   = full_ch[select];
    wr_en  = {4{write}} & (4'b1 << select) & ~full_ch;
    drop_d = (write && full && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) drop_q <= '0;
    else drop_q <= drop_d;
  end
  for (genvar g = 0; g < 4; g++) begin : g_ch
    demux_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
      .clock  (clock),
      .reset  (reset),
      .wr_i   (wr_en[g]),
      .din_i  (DATA_IN),
      .rd_i   (read[g]),
      .dout_o (dout[g]),
      .empty_o(empty[g]),
      .full_o (full_ch[g])
    );
  end
  assign DATA_OUT_A = dout[CH_A];
  assign DATA_OUT_B = dout[CH_B];
  assign DATA_OUT_C = dout[CH_C];
  assign DATA_OUT_D = dout[CH_D];
  assign drop_count = drop_q;
endmodule

// File: tb/tb_fifo_demux4.sv
// tb_fifo_demux4: randomized and directed scoreboard bench for fifo_demux4
module tb_fifo_demux4;
  localparam int DEPTH = 8;
  logic       clock = 0;
  logic       reset = 0;
  logic [7:0] DATA_IN = 0;
  logic       write = 0;
  logic [1:0] select = 0;
  logic [3:0] read = 0;
  logic       full;
  logic [3:0] full_ch, empty;
  logic [7:0] DATA_OUT_A, DATA_OUT_B, DATA_OUT_C, DATA_OUT_D, drop_count;
  logic [7:0] dout [4];
  int n_chk = 0, n_fail = 0;
  logic [7:0] mq [4][$];
  logic [7:0] exp_q [4][$];
  logic [7:0] last_exp [4];
  int drops = 0;

  fifo_demux4 dut (
    .clock(clock), .reset(reset), .DATA_IN(DATA_IN), .write(write), .select(select),
    .full(full), .full_ch(full_ch), .read(read), .empty(empty),
    .DATA_OUT_A(DATA_OUT_A), .DATA_OUT_B(DATA_OUT_B), .DATA_OUT_C(DATA_OUT_C),
    .DATA_OUT_D(DATA_OUT_D), .drop_count(drop_count)
  );
  assign dout[0] = DATA_OUT_A;
  assign dout[1] = DATA_OUT_B;
  assign dout[2] = DATA_OUT_C;
  assign dout[3] = DATA_OUT_D;

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      exp_q[i].delete();
      last_exp[i] = 0;
    end
    drops = 0;
  endtask

  // One clock of stimulus: check flags against the model, drive, then advance the model
  task automatic cycle(input logic w, input logic [1:0] s, input logic [3:0] r, input logic [7:0] d);
    logic [3:0] e_emp, e_full;
    logic       wfull;
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      e_emp[i]  = mq[i].size() == 0;
      e_full[i] = mq[i].size() == DEPTH;
    end
    chk("empty", empty, e_emp);
    chk("full_ch", full_ch, e_full);
    chk("drop_count", drop_count, drops);
    write = w; select = s; read = r; DATA_IN = d;
    #1;
    chk("full", full, e_full[s]);
    wfull = mq[s].size() >= DEPTH;
    for (int i = 0; i < 4; i++)
      if (r[i] && mq[i].size() > 0) exp_q[i].push_back(mq[i].pop_front());
    if (w) begin
      if (!wfull) mq[s].push_back(d);
      else if (drops < 255) drops++;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0);
  endtask

  // Monitor: pops the expected word whenever the DUT accepts a read, otherwise checks hold
  initial begin
    logic [3:0] pops;
    forever begin
      @(posedge clock);
      pops = read & ~empty;
      #1;
      for (int i = 0; i < 4; i++) begin
        if (pops[i]) begin
          if (exp_q[i].size() == 0) chk("unexpected_pop", 0, 1);
          else last_exp[i] = exp_q[i].pop_front();
        end
        chk($sformatf("dout%0d", i), dout[i], last_exp[i]);
      end
    end
  end

  initial begin
    model_clear();
    repeat (2) @(negedge clock);
    reset = 1;
    // routing
    cycle(1, 0, 0, 8'h05);
    cycle(1, 1, 0, 8'h08);
    cycle(1, 2, 0, 8'h0A);
    cycle(1, 3, 0, 8'h2D);
    cycle(0, 0, 4'hF, 0);
    idle(2);
    // fill and overflow on C
    for (int k = 1; k <= 9; k++) cycle(1, 2, 0, 8'(k));
    for (int k = 0; k < 8; k++) cycle(0, 0, 4'b0100, 0);
    idle(1);
    // wrap-around on B
    for (int k = 10; k < 16; k++) cycle(1, 1, 0, 8'(k));
    for (int k = 0; k < 6; k++) cycle(0, 0, 4'b0010, 0);
    for (int k = 10; k < 16; k++) cycle(1, 1, 0, 8'(k));
    for (int k = 0; k < 6; k++) cycle(0, 0, 4'b0010, 0);
    // simultaneous read/write on full then empty A
    for (int k = 0; k < 8; k++) cycle(1, 0, 0, 8'h40 + 8'(k));
    cycle(1, 0, 4'b0001, 8'hFF);
    for (int k = 0; k < 8; k++) cycle(0, 0, 4'b0001, 0);
    cycle(1, 0, 4'b0001, 8'hFF);
    cycle(0, 0, 4'b0001, 0);
    idle(1);
    // random traffic
    for (int k = 0; k < 400; k++)
      cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15) & $urandom_range(0, 15)), 8'($urandom));
    for (int k = 0; k < 10; k++) cycle(0, 0, 4'hF, 0);
    // async reset mid-stream with words in D
    for (int k = 0; k < 3; k++) cycle(1, 3, 0, 8'hD0 + 8'(k));
    cycle(0, 0, 4'b1000, 0);
    @(negedge clock);
    write = 0; read = 0;
    #2;
    reset = 0;
    model_clear();
    #1;
    chk("rst_empty", empty, 4'hF);
    chk("rst_full_ch", full_ch, 0);
    chk("rst_dout_d", DATA_OUT_D, 0);
    chk("rst_drop", drop_count, 0);
    @(negedge clock);
    reset = 1;
    idle(1);
    // drop_count saturation
    for (int k = 0; k < 8; k++) cycle(1, 0, 0, 8'(k));
    for (int k = 0; k < 300; k++) cycle(1, 0, 0, 8'hEE);
    chk("drop_sat_model", drops, 255);
    for (int k = 0; k < 9; k++) cycle(0, 0, 4'hF, 0);
    idle(2);
    for (int i = 0; i < 4; i++) chk($sformatf("pending%0d", i), exp_q[i].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
